// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end.
//   XLEN             - architectural register / address width
//   INSTR_BYTES      - bytes per instruction word (PC step)
//   RESET_PC_DEFAULT - default program counter loaded on reset
//   fetch_entry_t    - one prefetch FIFO slot: {pc, instr}
//   align_pc()       - forces a byte PC onto a word boundary
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instructions are always word aligned, so the two low PC bits are
  // simply discarded whenever a new PC is loaded.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Generic synchronous FIFO of fetch_entry_t used as the prefetch buffer.
// No bypass path: a pushed entry becomes visible at the head one cycle later.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high clear
//   flush      in   synchronous clear; wins over push
//   push       in   write push_data at the tail (ignored if full and no pop)
//   push_data  in   entry to write
//   pop        in   discard the head entry (ignored if empty)
//   head_data  out  entry at the head (all zero while empty)
//   head_valid out  FIFO holds at least one entry
//   count      out  number of occupied entries
// ---------------------------------------------------------------------------
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head_data,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A pop frees the head slot in the same edge, so a full FIFO can still
  // accept a push when it is also being popped.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for pointers, occupancy and storage. Flush empties the FIFO
  // by resetting the bookkeeping only; stale storage is masked at the head.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous clear; storage is cleared too so the
  // head never exposes leftover data after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head is read straight from the registered storage and forced to zero
  // while empty, so it only ever changes on a clock edge or reset.
  assign head_valid = ~empty;
  assign head_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch front end: owns the PC, drives the instruction memory
// address, captures the same-cycle instruction into a prefetch FIFO and
// hands {pc, instr} to decode over a valid/ready handshake.
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   fetch_en       in   allow new fetches; PC holds when low
//   redirect_valid in   flush the FIFO and load redirect_pc this edge
//   redirect_pc    in   new byte PC (low two bits ignored)
//   imem_addr      out  word-aligned byte address to instruction memory
//   imem_instr     in   instruction at imem_addr, valid in the same cycle
//   if_valid       out  FIFO head holds a valid instruction
//   if_instr       out  instruction at the FIFO head
//   if_pc          out  byte PC of if_instr
//   id_ready       in   decode accepts the head when if_valid is high
//   fifo_count     out  occupied prefetch entries
// ---------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_en,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic [XLEN-1:0]             imem_addr,
  input  logic [XLEN-1:0]             imem_instr,
  output logic                        if_valid,
  output logic [XLEN-1:0]             if_instr,
  output logic [XLEN-1:0]             if_pc,
  input  logic                        id_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pop;
  logic             push;
  logic             has_room;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic             head_valid;
  logic [CNT_W-1:0] count;

  // Decode takes the head whenever it is ready and there is something to
  // take; this still counts as accepted even if a redirect happens now.
  assign pop = head_valid & id_ready;

  // Room exists if the FIFO is not full, or if the head leaves this edge.
  assign has_room = (count < CNT_W'(FIFO_DEPTH)) | pop;

  // Redirect suppresses the push: the instruction on the bus belongs to the
  // old path and must not land in the freshly flushed FIFO.
  assign push = fetch_en & ~redirect_valid & has_room;

  assign push_entry = '{pc: pc_q, instr: imem_instr};

  // PC next-state: redirect beats everything, otherwise advance by one word
  // on each accepted fetch (natural 32-bit wrap) and hold otherwise.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (push) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= align_pc(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head_data  (head_entry),
    .head_valid (head_valid),
    .count      (count)
  );

  // No memory latency: the address is the PC register itself.
  assign imem_addr  = pc_q;
  assign if_valid   = head_valid;
  assign if_instr   = head_entry.instr;
  assign if_pc      = head_entry.pc;
  assign fifo_count = count;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. Two instances share a clock: dut_a uses
// the default reset PC and carries most scenarios, dut_b starts at
// 32'hFFFF_FFF8 to exercise PC wrap-around. Instruction memory is a small
// combinational model indexed by byte address.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] W0 = 32'h0022_1820;
  localparam logic [31:0] W1 = 32'h0022_2022;
  localparam logic [31:0] W2 = 32'h0022_1818;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [1:0]  fifo_count;

  logic        rst_b;
  logic [31:0] imem_addr_b;
  logic [31:0] imem_instr_b;
  logic        if_valid_b;
  logic [31:0] if_instr_b;
  logic [31:0] if_pc_b;
  logic [1:0]  fifo_count_b;

  int errors = 0;
  int checks = 0;

  // Memory model: three known words at the bottom of memory, anything else
  // returns the inverted address so entries remain distinguishable.
  function automatic logic [31:0] imem_model(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return W0;
      32'h0000_0004: return W1;
      32'h0000_0008: return W2;
      default:       return ~addr;
    endcase
  endfunction

  assign imem_instr   = imem_model(imem_addr);
  assign imem_instr_b = imem_model(imem_addr_b);

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut_a (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .fifo_count     (fifo_count)
  );

  instr_fetch #(
    .RESET_PC   (32'hFFFF_FFF8),
    .FIFO_DEPTH (2)
  ) dut_b (
    .clk            (clk),
    .rst            (rst_b),
    .fetch_en       (1'b1),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0000_0000),
    .imem_addr      (imem_addr_b),
    .imem_instr     (imem_instr_b),
    .if_valid       (if_valid_b),
    .if_instr       (if_instr_b),
    .if_pc          (if_pc_b),
    .id_ready       (1'b1),
    .fifo_count     (fifo_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then advance to just after the next rising
  // edge so outputs are sampled clear of the edge.
  task automatic applyStimulus(input logic fe, input logic rv,
                               input logic [31:0] rpc, input logic rdy);
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Check the whole decode-side view of dut_a at once.
  task automatic checkHead(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] instr, input logic [1:0] cnt,
                           input logic [31:0] addr);
    checkOutput({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    checkOutput({tag, ".pc"}, if_pc, pc);
    checkOutput({tag, ".instr"}, if_instr, instr);
    checkOutput({tag, ".count"}, {30'd0, fifo_count}, {30'd0, cnt});
    checkOutput({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    rst            = 1'b1;
    rst_b          = 1'b1;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    #1;

    // ---- 1: reset state, then steady streaming ----
    $display("[TB] reset and steady fetch");
    checkHead("rst", 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    checkOutput("rst_b.addr", imem_addr_b, 32'hFFFF_FFF8);
    checkOutput("rst_b.valid", {31'd0, if_valid_b}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkHead("s1.e1", 1'b1, 32'h0, W0, 2'd1, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkHead("s1.e2", 1'b1, 32'h4, W1, 2'd1, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkHead("s1.e3", 1'b1, 32'h8, W2, 2'd1, 32'hC);

    // ---- 2: backpressure from a fresh reset ----
    $display("[TB] backpressure");
    rst = 1'b1;
    #2;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkHead("s2.e1", 1'b1, 32'h0, W0, 2'd1, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkHead("s2.e2", 1'b1, 32'h0, W0, 2'd2, 32'h8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkHead("s2.hold", 1'b1, 32'h0, W0, 2'd2, 32'h8);
    end
    // Full plus pop: push still happens, count stays at two.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkHead("s2.rel1", 1'b1, 32'h4, W1, 2'd2, 32'hC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkHead("s2.rel2", 1'b1, 32'h8, W2, 2'd2, 32'h10);

    // ---- 3: redirect to a misaligned target while full ----
    $display("[TB] redirect while full");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkHead("s3.full", 1'b1, 32'h8, W2, 2'd2, 32'h10);
    applyStimulus(1'b1, 1'b1, 32'h0000_0006, 1'b0);
    checkHead("s3.flush", 1'b0, 32'h0, 32'h0, 2'd0, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkHead("s3.first", 1'b1, 32'h4, W1, 2'd1, 32'h8);

    // ---- 4: redirect and pop in the same cycle ----
    $display("[TB] redirect with pop");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkHead("s4.fill", 1'b1, 32'h4, W1, 2'd2, 32'hC);
    fetch_en       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    #1;
    // The entry being accepted by decode alongside the redirect.
    checkOutput("s4.popped", if_pc, 32'h4);
    @(posedge clk);
    #1;
    checkHead("s4.flush", 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkHead("s4.new0", 1'b1, 32'h0, W0, 2'd1, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkHead("s4.new1", 1'b1, 32'h4, W1, 2'd1, 32'h8);

    // ---- fetch disabled: pops drain, PC holds ----
    $display("[TB] fetch disabled");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkHead("fe0.drain", 1'b0, 32'h0, 32'h0, 2'd0, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkHead("fe0.hold", 1'b0, 32'h0, 32'h0, 2'd0, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkHead("fe1.resume", 1'b1, 32'h8, W2, 2'd1, 32'hC);

    // ---- 6: asynchronous reset with the FIFO full ----
    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkHead("s6.full", 1'b1, 32'h8, W2, 2'd2, 32'h10);
    rst = 1'b1;
    #2;
    checkHead("s6.rst", 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    rst = 1'b0;

    // ---- 5: PC wrap on the high reset vector ----
    $display("[TB] pc wrap");
    rst_b = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("s5.pc0", if_pc_b, 32'hFFFF_FFF8);
    checkOutput("s5.in0", if_instr_b, 32'h0000_0007);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("s5.pc1", if_pc_b, 32'hFFFF_FFFC);
    checkOutput("s5.addr1", imem_addr_b, 32'h0000_0000);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("s5.pc2", if_pc_b, 32'h0000_0000);
    checkOutput("s5.in2", if_instr_b, W0);
    checkOutput("s5.valid", {31'd0, if_valid_b}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
